// File: rtl/rr_mux41_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux controllers.
// State encodings and requester/select widths.
package rr_mux41_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request after ptr, wrapping mod 4.
// Purely combinational.
module rr_pick4
  import rr_mux41_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  // Scan farthest-first so the nearest candidate overwrites last.
  always_comb begin
    any = |req;
    win = ptr;
    idx = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) win = idx;
    end
  end

endmodule

// File: rtl/rr_mux41_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux with break-before-make.
// Optional MAX_HOLD eviction enabled by defining RRARB_TIMEOUT_EN.
module rr_mux41_arbiter
  import rr_mux41_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  a,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] s,
  output logic             y,
  output logic             valid,
  output logic             timeout
);

`ifdef RRARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             any;
  logic [SEL_W-1:0] win;
  logic             rel;
  logic             to_hit;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (any),
    .win (win)
  );

  assign rel    = ~req[s_q];
  assign to_hit = TO_EN & (hold_cnt_q == HOLD_LIM);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    s_d        = s_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d    = ST_OWN;
          s_d        = win;
          grant_d    = NREQ'(1) << win;
          valid_d    = 1'b1;
          ptr_d      = win;
          hold_cnt_d = '0;
        end
      end
      ST_OWN: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        // A release in the same cycle as the limit wins over eviction.
        if (rel || to_hit) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          valid_d   = 1'b0;
          timeout_d = to_hit & ~rel;
        end
      end
      ST_GAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      s_q        <= '0;
      ptr_q      <= 2'd3;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      s_q        <= s_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign s       = s_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign y       = valid_q ? a[s_q] : 1'b0;

endmodule
